pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches an opcode, executes it in one cycle by
// driving increment/load strobes toward an external PC register, and keeps a
// small return stack for CALL/RET. Overflow, underflow and HALT park the
// sequencer until reset.
//
// state | meaning
// FETCH | fetch_req high, waiting for fetch_ack to latch the opcode
// EXEC  | one cycle, strobes driven from the latched opcode
// HALT  | parked, only res leaves
module pc_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic [PC_WIDTH-1:0]          pc,
  output logic                         fetch_req,
  input  logic                         fetch_ack,
  input  logic [2:0]                   op_code,
  input  logic [PC_WIDTH-1:0]          op_arg,
  output logic                         pc_cnt_en,
  output logic                         pc_wr_en,
  output logic                         pc_add_offset,
  output logic [PC_WIDTH-1:0]          pc_target,
  output logic                         halted,
  output logic                         err_overflow,
  output logic                         err_underflow,
  output logic                         err_illegal,
  output logic [$clog2(STACK_DEPTH):0] sp
);

  localparam int SPW = $clog2(STACK_DEPTH) + 1;
  localparam int AW  = SPW - 1;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JREL = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            code_q, code_d;
  logic [PC_WIDTH-1:0]   arg_q, arg_d;
  logic [SPW-1:0]        sp_q, sp_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  ill_q, ill_d;
  logic [PC_WIDTH-1:0]   stack_q [STACK_DEPTH];
  logic [PC_WIDTH-1:0]   stack_d [STACK_DEPTH];

  logic [PC_WIDTH-1:0]   pc_plus1;
  logic [AW-1:0]         push_idx;
  logic [AW-1:0]         pop_idx;
  logic                  stack_full;
  logic                  stack_empty;

  // Stack pointer arithmetic; the low bits of sp index the next free slot,
  // and sp-1 (mod depth) is the top entry whenever sp is non-zero.
  always_comb begin
    pc_plus1    = pc + PC_WIDTH'(1);
    push_idx    = sp_q[AW-1:0];
    pop_idx     = sp_q[AW-1:0] - AW'(1);
    stack_full  = (sp_q == SPW'(STACK_DEPTH));
    stack_empty = (sp_q == '0);
  end

  // Next-state, stack update and strobe decode; reset overrides everything last.
  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    arg_d         = arg_q;
    sp_d          = sp_q;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    ill_d         = ill_q;
    stack_d       = stack_q;
    pc_cnt_en     = 1'b0;
    pc_wr_en      = 1'b0;
    pc_add_offset = 1'b0;
    pc_target     = '0;

    unique case (state_q)
      FETCH: begin
        if (fetch_ack) begin
          code_d  = op_code;
          arg_d   = op_arg;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH;
        unique case (code_q)
          OP_NOP: pc_cnt_en = 1'b1;
          OP_JMP: begin
            pc_wr_en  = 1'b1;
            pc_target = arg_q;
          end
          OP_JREL: begin
            pc_wr_en      = 1'b1;
            pc_add_offset = 1'b1;
            pc_target     = arg_q;
          end
          OP_CALL: begin
            if (!stack_full) begin
              stack_d[push_idx] = pc_plus1;
              sp_d              = sp_q + SPW'(1);
              pc_wr_en          = 1'b1;
              pc_target         = arg_q;
            end else begin
              ovf_d   = 1'b1;
              state_d = HALT;
            end
          end
          OP_RET: begin
            if (!stack_empty) begin
              sp_d      = sp_q - SPW'(1);
              pc_wr_en  = 1'b1;
              pc_target = stack_q[pop_idx];
            end else begin
              unf_d   = 1'b1;
              state_d = HALT;
            end
          end
          OP_HALT: state_d = HALT;
          default: begin
            pc_cnt_en = 1'b1;
            ill_d     = 1'b1;
          end
        endcase
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase

    if (res) begin
      state_d       = FETCH;
      code_d        = '0;
      arg_d         = '0;
      sp_d          = '0;
      ovf_d         = 1'b0;
      unf_d         = 1'b0;
      ill_d         = 1'b0;
      stack_d       = stack_q;
      pc_cnt_en     = 1'b0;
      pc_wr_en      = 1'b0;
      pc_add_offset = 1'b0;
      pc_target     = '0;
    end
  end

  // Control state register with synchronous reset applied through the _d path.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    code_q  <= code_d;
    arg_q   <= arg_d;
    sp_q    <= sp_d;
    ovf_q   <= ovf_d;
    unf_q   <= unf_d;
    ill_q   <= ill_d;
  end

  // Stack storage; entries above sp are never read, so no reset is needed.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign fetch_req     = (state_q == FETCH);
  assign halted        = (state_q == HALT);
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
  assign err_illegal   = ill_q;
  assign sp            = sp_q;

endmodule
